// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 add/sub/mul unit.
package pa_fpu;

    localparam int unsigned FPU_BIAS = 127;
    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        op_add  = 2'd0,
        op_sub  = 2'd1,
        op_mul  = 2'd2,
        op_rsvd = 2'd3
    } e_fpu_op;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StCompute,
        StNormalize,
        StRound,
        StDone
    } e_fpu_state;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } st_ieee_fields;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input yields Width.
module fpu_lzc #(
    parameter int unsigned Width = 27,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] data,
    output logic [CntW-1:0]  count
);

    always_comb begin
        count = CntW'(Width);
        // Scanning upward leaves the count of the highest set bit.
        for (int i = 0; i < int'(Width); i++) begin
            if (data[i]) begin
                count = CntW'(int'(Width) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu.sv
// Multi-cycle binary32 add/sub/mul with round-to-nearest-even and a start/cmd_end handshake.
module fpu
    import pa_fpu::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  e_fpu_op     operation,
    output logic [31:0] ieee_packet_out,
    output logic        cmd_end,
    output logic        busy
);

    e_fpu_state  state_q;
    logic [31:0] a_q, b_q;
    e_fpu_op     op_q;
    logic        sa_q, sb_q, sign_q, eff_sub_q, special_q, zero_q;
    logic [7:0]  ea_q, eb_q;
    logic [23:0] ma_q, mb_q;
    logic [31:0] special_val_q;
    logic [9:0]  exp_q;
    logic [26:0] x_q, y_q, norm_q;
    logic [27:0] sum_q;

    st_ieee_fields fa, fb;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sb_eff, sp;
    logic [31:0] sp_val;

    always_comb begin
        fa     = a_q;
        fb     = b_q;
        a_zero = (fa.exp == 8'h00);
        b_zero = (fb.exp == 8'h00);
        a_inf  = (fa.exp == 8'hFF) && (fa.frac == 23'd0);
        b_inf  = (fb.exp == 8'hFF) && (fb.frac == 23'd0);
        a_nan  = (fa.exp == 8'hFF) && (fa.frac != 23'd0);
        b_nan  = (fb.exp == 8'hFF) && (fb.frac != 23'd0);
        sb_eff = fb.sign ^ (op_q == op_sub);
        sp     = 1'b1;
        sp_val = FPU_QNAN;
        if (op_q == op_rsvd || a_nan || b_nan) begin
            sp_val = FPU_QNAN;
        end else if (op_q == op_mul) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) sp_val = FPU_QNAN;
            else if (a_inf || b_inf) sp_val = {fa.sign ^ fb.sign, 8'hFF, 23'd0};
            else if (a_zero || b_zero) sp_val = {fa.sign ^ fb.sign, 31'd0};
            else sp = 1'b0;
        end else begin
            if (a_inf && b_inf) sp_val = (fa.sign != sb_eff) ? FPU_QNAN : {fa.sign, 8'hFF, 23'd0};
            else if (a_inf) sp_val = {fa.sign, 8'hFF, 23'd0};
            else if (b_inf) sp_val = {sb_eff, 8'hFF, 23'd0};
            else if (a_zero && b_zero) sp_val = {fa.sign & sb_eff, 31'd0};
            else sp = 1'b0;
        end
    end

    logic        a_big;
    logic [7:0]  e_big, e_small, diff;
    logic [23:0] m_big, m_small;
    logic [4:0]  shamt;
    logic [26:0] small_ext, shifted, lost, y_al;
    logic [9:0]  exp_mul;

    always_comb begin
        a_big     = {ea_q, ma_q} >= {eb_q, mb_q};
        e_big     = a_big ? ea_q : eb_q;
        e_small   = a_big ? eb_q : ea_q;
        m_big     = a_big ? ma_q : mb_q;
        m_small   = a_big ? mb_q : ma_q;
        diff      = e_big - e_small;
        shamt     = (diff > 8'd26) ? 5'd26 : diff[4:0];
        small_ext = {m_small, 3'b000};
        shifted   = small_ext >> shamt;
        lost      = small_ext & ~({27{1'b1}} << shamt);
        y_al      = {shifted[26:1], shifted[0] | (|lost)};
        exp_mul   = {2'b00, ea_q} + {2'b00, eb_q} - 10'(FPU_BIAS);
    end

    logic [47:0] prod;
    logic [27:0] sum_d;

    always_comb begin
        prod = ma_q * mb_q;
        // Product maps onto the adder layout: bit 27 is carry, hidden bit at 26, GRS in [2:0].
        if (op_q == op_mul) sum_d = {prod[47:21], |prod[20:0]};
        else if (eff_sub_q) sum_d = {1'b0, x_q} - {1'b0, y_q};
        else sum_d = {1'b0, x_q} + {1'b0, y_q};
    end

    logic [4:0]  lz;
    logic [26:0] norm_d;
    logic [9:0]  exp_norm;

    fpu_lzc #(
        .Width (27),
        .CntW  (5)
    ) u_lzc (
        .data  (sum_q[26:0]),
        .count (lz)
    );

    always_comb begin
        if (sum_q[27]) begin
            norm_d   = {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_norm = exp_q + 10'd1;
        end else begin
            norm_d   = sum_q[26:0] << lz;
            exp_norm = exp_q - 10'(lz);
        end
    end

    logic        round_up;
    logic [24:0] mant_r;
    logic [9:0]  exp_r;
    logic [31:0] result;

    always_comb begin
        round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        mant_r   = {1'b0, norm_q[26:3]} + 25'(round_up);
        exp_r    = exp_q + 10'(mant_r[24]);
        if (special_q) result = special_val_q;
        else if (zero_q) result = 32'd0;
        else if ($signed(exp_r) >= 10'sd255) result = {sign_q, 8'hFF, 23'd0};
        else if ($signed(exp_r) <= 10'sd0) result = {sign_q, 31'd0};
        else result = {sign_q, exp_r[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q         <= StIdle;
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= op_add;
            sa_q            <= 1'b0;
            sb_q            <= 1'b0;
            ea_q            <= '0;
            eb_q            <= '0;
            ma_q            <= '0;
            mb_q            <= '0;
            special_q       <= 1'b0;
            special_val_q   <= '0;
            sign_q          <= 1'b0;
            eff_sub_q       <= 1'b0;
            exp_q           <= '0;
            x_q             <= '0;
            y_q             <= '0;
            sum_q           <= '0;
            norm_q          <= '0;
            zero_q          <= 1'b0;
            ieee_packet_out <= '0;
            cmd_end         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a_operand;
                        b_q     <= b_operand;
                        op_q    <= operation;
                        busy    <= 1'b1;
                        state_q <= StUnpack;
                    end
                end
                StUnpack: begin
                    sa_q          <= fa.sign;
                    sb_q          <= sb_eff;
                    ea_q          <= a_zero ? 8'd0 : fa.exp;
                    eb_q          <= b_zero ? 8'd0 : fb.exp;
                    ma_q          <= a_zero ? 24'd0 : {1'b1, fa.frac};
                    mb_q          <= b_zero ? 24'd0 : {1'b1, fb.frac};
                    special_q     <= sp;
                    special_val_q <= sp_val;
                    state_q       <= StAlign;
                end
                StAlign: begin
                    if (op_q == op_mul) begin
                        sign_q <= sa_q ^ sb_q;
                        exp_q  <= exp_mul;
                    end else begin
                        sign_q    <= a_big ? sa_q : sb_q;
                        exp_q     <= {2'b00, e_big};
                        x_q       <= {m_big, 3'b000};
                        y_q       <= y_al;
                        eff_sub_q <= sa_q ^ sb_q;
                    end
                    state_q <= StCompute;
                end
                StCompute: begin
                    sum_q   <= sum_d;
                    state_q <= StNormalize;
                end
                StNormalize: begin
                    norm_q  <= norm_d;
                    exp_q   <= exp_norm;
                    zero_q  <= (sum_q == 28'd0);
                    state_q <= StRound;
                end
                StRound: begin
                    ieee_packet_out <= result;
                    cmd_end         <= 1'b1;
                    state_q         <= StDone;
                end
                StDone: begin
                    cmd_end <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu: results, handshake latency, busy, and mid-op reset.
module tb_fpu;
    import pa_fpu::*;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic [31:0] a_operand, b_operand;
    e_fpu_op     operation;
    logic [31:0] ieee_packet_out;
    logic        cmd_end;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // DONE is entered on the 5th edge after the sampling edge (6th counting that edge).
    localparam int Latency = 5;

    fpu dut (
        .clk             (clk),
        .arst            (arst),
        .start           (start),
        .a_operand       (a_operand),
        .b_operand       (b_operand),
        .operation       (operation),
        .ieee_packet_out (ieee_packet_out),
        .cmd_end         (cmd_end),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op,
                          input logic [31:0] exp, input string tag);
        int          pulses;
        int          lat;
        logic        busy_ok;
        logic [31:0] res;
        pulses = 0;
        lat    = 0;
        res    = 32'hDEADBEEF;
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        operation = op;
        start     = 1'b1;
        @(posedge clk);
        #1;
        busy_ok   = (busy === 1'b1);
        start     = 1'b0;
        // Scramble inputs to prove the operands were latched.
        a_operand = ~a;
        b_operand = ~b;
        operation = op_rsvd;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (cmd_end === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    res = ieee_packet_out;
                end
            end
            if (busy !== (i <= Latency)) busy_ok = 1'b0;
        end
        chk({tag, "_result"}, res, exp);
        chk({tag, "_latency"}, 32'(lat), 32'(Latency));
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_hold"}, ieee_packet_out, exp);
    endtask

    initial begin
        int   pulses;
        logic busy_seen;
        arst      = 1'b1;
        start     = 1'b0;
        a_operand = '0;
        b_operand = '0;
        operation = op_add;
        #1;
        chk("reset_out", ieee_packet_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cmd_end", {31'd0, cmd_end}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;

        run_op(32'h412DF854, 32'h43ADF854, op_add, 32'h43B36817, "add_frac");
        run_op(32'h3F800000, 32'h3F800000, op_add, 32'h40000000, "add_1_1");
        run_op(32'h40400000, 32'h3F800000, op_sub, 32'h40000000, "sub_3_1");
        run_op(32'h40400000, 32'h40400000, op_sub, 32'h00000000, "sub_zero");
        run_op(32'h40000000, 32'h40400000, op_mul, 32'h40C00000, "mul_2_3");
        run_op(32'h7F7FFFFF, 32'h40000000, op_mul, 32'h7F800000, "mul_ovf");
        run_op(32'h7F800000, 32'hFF800000, op_add, 32'h7FC00000, "inf_m_inf");
        run_op(32'h4B800000, 32'h3F800000, op_add, 32'h4B800000, "tie_even");
        run_op(32'h3F800000, 32'h3F800000, op_rsvd, 32'h7FC00000, "rsvd_op");
        run_op(32'h80000000, 32'h80000000, op_add, 32'h80000000, "neg_zero");

        // Abort: reset two edges after the sampling edge.
        @(negedge clk);
        a_operand = 32'h40000000;
        b_operand = 32'h40400000;
        operation = op_mul;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b1;
        #2;
        chk("abort_out", ieee_packet_out, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cmd_end", {31'd0, cmd_end}, 32'd0);
        @(negedge clk);
        arst      = 1'b0;
        pulses    = 0;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (cmd_end === 1'b1) pulses++;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        chk("abort_idle", {31'd0, busy_seen}, 32'd0);

        run_op(32'h40000000, 32'h40400000, op_mul, 32'h40C00000, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
